// File: rtl/alu_mdu.sv
// Execute-stage ALU with iterative multiply/divide: single-cycle ops ready the edge after accept, ops 12-15 after W more edges.
// One op in flight; result held in DONE until out_ready_i, and in_ready_o drops while the result is unconsumed.
module alu_mdu #(
  parameter int ALU_DAT_WIDTH = 32,
  parameter int ALU_OP_BUS    = 4,
  parameter bit MDU_EN        = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [ALU_DAT_WIDTH-1:0] in_0_i,
  input  logic [ALU_DAT_WIDTH-1:0] in_1_i,
  input  logic [ALU_OP_BUS-1:0]    op_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [ALU_DAT_WIDTH-1:0] out_o,
  output logic                     of_o,
  output logic                     dz_o,
  output logic                     busy_o
);

  localparam int W  = ALU_DAT_WIDTH;
  localparam int SW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_in, op_q;
  logic            is_mdu_in, accept, last_iter;
  logic [W-1:0]    opa_q, opb_q, out_q;
  logic [2*W-1:0]  acc_q, acc_next, mul_next, div_next;
  logic [SW-1:0]   cnt_q;
  logic            of_q, dz_q;
  logic [W-1:0]    res_d, sum_ab, dif_ab, iter_res;
  logic            of_d, div_ge;
  logic [SW-1:0]   sh;
  logic [W:0]      mul_sum, div_trial, div_rem;

  assign op_in      = op_i[3:0];
  assign is_mdu_in  = (MDU_EN != 1'b0) && (op_in[3:2] == 2'b11);
  assign in_ready_o = (state_q == S_IDLE) || (state_q == S_DONE && out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign last_iter  = (cnt_q == SW'(W - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = is_mdu_in ? S_ITER : S_DONE;
      S_ITER: if (last_iter) state_d = S_DONE;
      S_DONE: if (out_ready_i) state_d = accept ? (is_mdu_in ? S_ITER : S_DONE) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle datapath, evaluated on the live inputs at accept.
  always_comb begin
    sum_ab = in_0_i + in_1_i;
    dif_ab = in_0_i - in_1_i;
    sh     = in_1_i[SW-1:0];
    res_d  = in_0_i;
    of_d   = 1'b0;
    case (op_in)
      4'd0:  res_d = in_0_i & in_1_i;
      4'd1:  res_d = in_0_i | in_1_i;
      4'd2:  res_d = in_0_i ^ in_1_i;
      4'd3: begin
        res_d = sum_ab;
        of_d  = (in_0_i[W-1] == in_1_i[W-1]) && (sum_ab[W-1] != in_0_i[W-1]);
      end
      4'd4:  res_d = sum_ab;
      4'd5: begin
        res_d = dif_ab;
        of_d  = (in_0_i[W-1] != in_1_i[W-1]) && (dif_ab[W-1] != in_0_i[W-1]);
      end
      4'd6:  res_d = dif_ab;
      4'd7:  res_d = in_0_i >> sh;
      4'd8:  res_d = in_0_i << sh;
      4'd9:  res_d = $signed(in_0_i) >>> sh;
      4'd10: res_d = {{(W-1){1'b0}}, ($signed(in_0_i) < $signed(in_1_i))};
      4'd11: res_d = {{(W-1){1'b0}}, (in_0_i < in_1_i)};
      default: res_d = in_0_i;
    endcase
  end

  // Multiply: {hi, multiplier} shifts right, adding A into hi when the LSB is set.
  // Divide: {rem, dividend} shifts left, quotient bits enter at the LSB.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_trial = {acc_q[2*W-1:W], acc_q[W-1]};
    div_ge    = (div_trial >= {1'b0, opb_q});
    div_rem   = div_ge ? (div_trial - {1'b0, opb_q}) : div_trial;
    div_next  = {div_rem[W-1:0], acc_q[W-2:0], div_ge};
    acc_next  = op_q[1] ? div_next : mul_next;
    iter_res  = op_q[0] ? acc_next[2*W-1:W] : acc_next[W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      of_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op_in;
        opa_q <= in_0_i;
        opb_q <= in_1_i;
        cnt_q <= '0;
        if (is_mdu_in) begin
          acc_q <= op_in[1] ? {{W{1'b0}}, in_0_i} : {{W{1'b0}}, in_1_i};
          of_q  <= 1'b0;
          dz_q  <= op_in[1] && (in_1_i == '0);
        end else begin
          out_q <= res_d;
          of_q  <= of_d;
          dz_q  <= 1'b0;
        end
      end else if (state_q == S_ITER) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + SW'(1);
        if (last_iter) out_q <= iter_res;
      end
    end
  end

  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q == S_ITER);
  assign out_o       = out_q;
  assign of_o        = of_q;
  assign dz_o        = dz_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu (W=32): hand-computed vectors, timing, backpressure and mid-op reset.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, of_f, dz_f, busy;
  logic [31:0] in_0, in_1, out_d;
  logic [3:0]  op;
  int          passed = 0;
  int          total  = 0;
  int          k, busy_n;
  logic [31:0] held;

  always #5 clk = ~clk;

  alu_mdu #(.ALU_DAT_WIDTH(32), .ALU_OP_BUS(4), .MDU_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_0_i(in_0), .in_1_i(in_1), .op_i(op),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_o(out_d), .of_o(of_f), .dz_o(dz_f), .busy_o(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for one edge, then scrambles operands to prove they were captured.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    op = o; in_0 = a; in_1 = b;
    step();
    in_valid = 1'b0;
    op = 4'd2; in_0 = 32'hDEAD_BEEF; in_1 = 32'h1234_5678;
  endtask

  // Counts edges from the accept edge until out_valid, bounded.
  task automatic wait_done(output int n, output int bn);
    n = 0; bn = 0;
    while (!out_valid && n < 200) begin
      if (busy) bn++;
      step();
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; in_0 = '0; in_1 = '0;
    repeat (2) step();
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out", out_d, 0);
    check("rst_of", of_f, 0);
    check("rst_dz", dz_f, 0);
    check("rst_ready", in_ready, 1);

    issue(4'd3, 32'h7FFF_FFFF, 32'h1);
    check("adds_valid", out_valid, 1);
    check("adds_out", out_d, 32'h8000_0000);
    check("adds_of", of_f, 1);
    check("b2b_ready", in_ready, 1);
    issue(4'd4, 32'h7FFF_FFFF, 32'h1);
    check("addu_out", out_d, 32'h8000_0000);
    check("addu_of", of_f, 0);
    issue(4'd5, 32'h8000_0000, 32'h1);
    check("subs_out", out_d, 32'h7FFF_FFFF);
    check("subs_of", of_f, 1);
    issue(4'd9, 32'h8000_0000, 32'h4);
    check("shra_out", out_d, 32'hF800_0000);
    issue(4'd7, 32'h8000_0000, 32'h24);
    check("shrl_amt_low_bits", out_d, 32'h0800_0000);
    issue(4'd8, 32'h0000_0003, 32'h1F);
    check("shll_out", out_d, 32'h8000_0000);
    issue(4'd10, 32'hFFFF_FFFF, 32'h1);
    check("slt_out", out_d, 32'h1);
    issue(4'd11, 32'hFFFF_FFFF, 32'h1);
    check("sltu_out", out_d, 32'h0);
    issue(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check("xor_out", out_d, 32'h0FF0_0FF0);

    issue(4'd12, 32'hFFFF_FFFF, 32'h2);
    check("mul_busy_first", busy, 1);
    check("mul_not_ready", in_ready, 0);
    wait_done(k, busy_n);
    check("mul_latency", k, 32);
    check("mul_busy_cycles", busy_n, 32);
    check("mul_out", out_d, 32'hFFFF_FFFE);
    issue(4'd13, 32'hFFFF_FFFF, 32'h2);
    wait_done(k, busy_n);
    check("mulhu_out", out_d, 32'h1);
    issue(4'd14, 32'd100, 32'd7);
    wait_done(k, busy_n);
    check("divu_latency", k, 32);
    check("divu_out", out_d, 32'd14);
    check("divu_dz", dz_f, 0);
    issue(4'd15, 32'd100, 32'd7);
    wait_done(k, busy_n);
    check("remu_out", out_d, 32'd2);
    issue(4'd14, 32'd100, 32'd0);
    wait_done(k, busy_n);
    check("divu0_latency", k, 32);
    check("divu0_out", out_d, 32'hFFFF_FFFF);
    check("divu0_dz", dz_f, 1);
    issue(4'd15, 32'd100, 32'd0);
    wait_done(k, busy_n);
    check("remu0_out", out_d, 32'd100);
    check("remu0_dz", dz_f, 1);

    step();
    check("drain_idle", out_valid, 0);
    out_ready = 1'b0;
    issue(4'd0, 32'h0000_F0F0, 32'h0000_FF00);
    held = out_d;
    check("bp_first", held, 32'h0000_F000);
    in_valid = 1'b1; op = 4'd4; in_0 = 32'd5; in_1 = 32'd6;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready_low", in_ready, 0);
      step();
      check("bp_out_hold", out_d, held);
      check("bp_valid_hold", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_out", out_d, 32'd11);
    step();

    issue(4'd14, 32'd100, 32'd7);
    repeat (10) step();
    check("mid_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_valid", out_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_out", out_d, 0);
    check("mr_of", of_f, 0);
    check("mr_dz", dz_f, 0);
    check("mr_ready", in_ready, 1);
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid || busy) busy_n++;
      step();
    end
    check("mr_no_result", busy_n, 0);
    issue(4'd0, 32'h0000_000F, 32'h0000_003C);
    check("post_and_valid", out_valid, 1);
    check("post_and_out", out_d, 32'h0000_000C);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
